// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings, redirect classes and default vectors for the fetch-stage PC unit.
// Pure declarations; no logic, no latency, no flow control.
package pc_fetch_unit_pkg;

  localparam int          AW_DEF        = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;

  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLEZ = 3'b100;
  localparam logic [2:0] BR_BGTZ = 3'b101;
  localparam logic [2:0] BR_BLTZ = 3'b110;
  localparam logic [2:0] BR_BGEZ = 3'b111;

  // Jump ops are decoded on bits [2:1]; bit 0 only distinguishes the linking form.
  localparam logic [1:0] JMP_J   = 2'b10;
  localparam logic [1:0] JMP_JR  = 2'b11;

  // Enum order is the redirect priority order (higher value wins).
  typedef enum logic [2:0] {
    RC_NONE = 3'd0,
    RC_JR   = 3'd1,
    RC_J    = 3'd2,
    RC_BR   = 3'd3,
    RC_ERET = 3'd4,
    RC_INTR = 3'd5
  } redir_cls_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } fetch_state_e;

  function automatic logic is_exc_cls(input redir_cls_e cls);
    return (cls == RC_INTR) || (cls == RC_ERET);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_target.sv
// Next-PC target and branch-condition evaluation for the D-stage instruction.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs every cycle.
module npc_target
  import pc_fetch_unit_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          d_valid,
  input  logic [2:0]    br_op,
  input  logic [2:0]    jmp_op,
  input  logic [AW-1:0] d_pc4,
  input  logic [15:0]   d_imm16,
  input  logic [25:0]   d_idx26,
  input  logic [AW-1:0] rs_val,
  input  logic [AW-1:0] rt_val,
  output redir_cls_e    d_cls,
  output logic [AW-1:0] d_tgt
);

  logic [AW-1:0] imm_sext;
  logic [AW-1:0] br_tgt;
  logic [AW-1:0] j_tgt;
  logic          is_br;
  logic          br_taken;
  logic          rs_eq_rt;
  logic          rs_neg;
  logic          rs_zero;

  always_comb begin
    imm_sext = {{(AW-16){d_imm16[15]}}, d_imm16};
    br_tgt   = d_pc4 + {imm_sext[AW-3:0], 2'b00};
    j_tgt    = {d_pc4[AW-1:28], d_idx26, 2'b00};
    rs_eq_rt = (rs_val == rt_val);
    rs_neg   = rs_val[AW-1];
    rs_zero  = (rs_val == '0);
  end

  always_comb begin
    is_br    = 1'b1;
    br_taken = 1'b0;
    case (br_op)
      BR_BEQ:  br_taken = rs_eq_rt;
      BR_BNE:  br_taken = ~rs_eq_rt;
      BR_BLEZ: br_taken = rs_neg | rs_zero;
      BR_BGTZ: br_taken = ~rs_neg & ~rs_zero;
      BR_BLTZ: br_taken = rs_neg;
      BR_BGEZ: br_taken = ~rs_neg;
      default: is_br    = 1'b0;
    endcase
  end

  // A valid branch encoding shadows any jump encoding, taken or not.
  always_comb begin
    d_cls = RC_NONE;
    d_tgt = br_tgt;
    if (d_valid) begin
      if (is_br) begin
        if (br_taken) begin
          d_cls = RC_BR;
          d_tgt = br_tgt;
        end
      end else if (jmp_op[2:1] == JMP_J) begin
        d_cls = RC_J;
        d_tgt = j_tgt;
      end else if (jmp_op[2:1] == JMP_JR) begin
        d_cls = RC_JR;
        d_tgt = rs_val;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// F-stage PC register with prioritised redirects and a one-entry pending redirect buffer.
// Redirect reaches pc_f one cycle after it is seen on an advancing cycle, else on the first advancing cycle.
// Fetch advances only on imem_req_ready & ~stall_f; redirects seen while held are parked, never dropped.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int          AW        = AW_DEF,
  parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEF),
  parameter logic [AW-1:0] EXC_VEC   = AW'(EXC_VEC_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_f,
  output logic          imem_req_valid,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_req_ready,
  output logic [AW-1:0] pc_f,
  output logic          f_kill,
  input  logic          intr,
  input  logic          eret,
  input  logic [AW-1:0] epc,
  input  logic          d_valid,
  input  logic [2:0]    br_op,
  input  logic [2:0]    jmp_op,
  input  logic [AW-1:0] d_pc4,
  input  logic [15:0]   d_imm16,
  input  logic [25:0]   d_idx26,
  input  logic [AW-1:0] rs_val,
  input  logic [AW-1:0] rt_val
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pend_tgt_q, pend_tgt_d;
  redir_cls_e    pend_src_q, pend_src_d;
  logic          req_vld_q, req_vld_d;

  redir_cls_e    d_cls;
  logic [AW-1:0] d_tgt;
  redir_cls_e    live_cls;
  logic [AW-1:0] live_tgt;
  logic          exc_live;
  logic          adv;

  npc_target #(.AW(AW)) u_npc_target (
    .d_valid (d_valid),
    .br_op   (br_op),
    .jmp_op  (jmp_op),
    .d_pc4   (d_pc4),
    .d_imm16 (d_imm16),
    .d_idx26 (d_idx26),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .d_cls   (d_cls),
    .d_tgt   (d_tgt)
  );

  always_comb begin
    live_cls = d_cls;
    live_tgt = d_tgt;
    if (intr) begin
      live_cls = RC_INTR;
      live_tgt = EXC_VEC;
    end else if (eret) begin
      live_cls = RC_ERET;
      live_tgt = epc;
    end
    exc_live = intr | eret;
    // No advance before the first request is actually presented after reset.
    adv      = req_vld_q & imem_req_ready & ~stall_f;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_src_d = pend_src_q;
    req_vld_d  = 1'b1;
    case (state_q)
      ST_RUN: begin
        if (adv) begin
          pc_d = (live_cls != RC_NONE) ? live_tgt : pc_q + AW'(4);
        end else if (live_cls != RC_NONE) begin
          pend_tgt_d = live_tgt;
          pend_src_d = live_cls;
          state_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (adv) begin
          pc_d       = exc_live ? live_tgt : pend_tgt_q;
          pend_src_d = RC_NONE;
          state_d    = ST_RUN;
        end else if (exc_live && (live_cls > pend_src_q)) begin
          // Only interrupt/ERET may displace a parked redirect.
          pend_tgt_d = live_tgt;
          pend_src_d = live_cls;
        end
      end
      default: begin
        state_d    = ST_RUN;
        pend_src_d = RC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VEC;
      pend_tgt_q <= '0;
      pend_src_q <= RC_NONE;
      req_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_src_q <= pend_src_d;
      req_vld_q  <= req_vld_d;
    end
  end

  assign pc_f           = pc_q;
  assign imem_req_addr  = pc_q;
  assign imem_req_valid = req_vld_q;
  assign f_kill         = exc_live | ((state_q == ST_PEND) && is_exc_cls(pend_src_q));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed-vector bench for pc_fetch_unit: driver queues expected fetch address/kill,
// a negedge monitor pops and compares on every accepted request.
module tb_pc_fetch_unit;

  typedef struct {
    logic [31:0] addr;
    logic        kill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic [31:0] pc_f;
  logic        f_kill;
  logic        intr;
  logic        eret;
  logic [31:0] epc;
  logic        d_valid;
  logic [2:0]  br_op;
  logic [2:0]  jmp_op;
  logic [31:0] d_pc4;
  logic [15:0] d_imm16;
  logic [25:0] d_idx26;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  pc_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall_f        (stall_f),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .pc_f           (pc_f),
    .f_kill         (f_kill),
    .intr           (intr),
    .eret           (eret),
    .epc            (epc),
    .d_valid        (d_valid),
    .br_op          (br_op),
    .jmp_op         (jmp_op),
    .d_pc4          (d_pc4),
    .d_imm16        (d_imm16),
    .d_idx26        (d_idx26),
    .rs_val         (rs_val),
    .rt_val         (rt_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted fetch must match the next queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_fetch: got addr %h expected no request", imem_req_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("fetch_addr", imem_req_addr, e.addr);
        check("f_kill", {31'd0, f_kill}, {31'd0, e.kill});
      end
    end
  end

  task automatic clear_redirects();
    intr    = 1'b0;
    eret    = 1'b0;
    d_valid = 1'b0;
    br_op   = 3'b000;
    jmp_op  = 3'b000;
  endtask

  task automatic set_br(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] pc4, input logic [15:0] imm);
    d_valid = 1'b1;
    br_op   = op;
    rs_val  = rs;
    rt_val  = rt;
    d_pc4   = pc4;
    d_imm16 = imm;
  endtask

  // One cycle: apply ready/stall, queue the expected request if it will be accepted.
  task automatic step(input logic rdy, input logic stl, input logic [31:0] ea, input logic ek);
    imem_req_ready = rdy;
    stall_f        = stl;
    if (rdy) exp_q.push_back('{addr: ea, kill: ek});
    @(posedge clk);
    #1;
    clear_redirects();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    stall_f        = 1'b0;
    imem_req_ready = 1'b0;
    epc            = '0;
    d_pc4          = '0;
    d_imm16        = '0;
    d_idx26        = '0;
    rs_val         = '0;
    rt_val         = '0;
    clear_redirects();

    repeat (2) @(posedge clk);
    #1;
    check("reset_pc", pc_f, 32'h0000_3000);
    check("reset_valid", {31'd0, imem_req_valid}, 32'd0);
    check("reset_kill", {31'd0, f_kill}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Sequential fetch after reset.
    step(1, 0, 32'h0000_3000, 0);
    step(1, 0, 32'h0000_3004, 0);
    step(1, 0, 32'h0000_3008, 0);
    // beq taken: 3010 + (4<<2) = 3020.
    set_br(3'b001, 32'd5, 32'd5, 32'h0000_3010, 16'h0004);
    step(1, 0, 32'h0000_300C, 0);
    // beq not taken: sequential.
    set_br(3'b001, 32'd5, 32'd6, 32'h0000_3010, 16'h0004);
    step(1, 0, 32'h0000_3020, 0);
    // bne taken under 3 cycles of back-pressure.
    set_br(3'b010, 32'd1, 32'd2, 32'h0000_3010, 16'h0004);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    step(1, 0, 32'h0000_3024, 0);
    step(1, 0, 32'h0000_3020, 0);
    // intr and jr together: exception vector wins, kill live this cycle.
    intr    = 1'b1;
    d_valid = 1'b1;
    jmp_op  = 3'b110;
    rs_val  = 32'h0000_3400;
    step(1, 0, 32'h0000_3024, 1);
    step(1, 0, 32'h0000_4180, 0);
    // Pending branch, then intr during stall overrides it.
    set_br(3'b001, 32'd7, 32'd7, 32'h0000_3010, 16'h0004);
    step(1, 1, 32'h0000_4184, 0);
    intr = 1'b1;
    step(1, 1, 32'h0000_4184, 1);
    step(1, 1, 32'h0000_4184, 1);
    step(1, 0, 32'h0000_4184, 1);
    // eret to 3024.
    eret = 1'b1;
    epc  = 32'h0000_3024;
    step(1, 0, 32'h0000_4180, 1);
    step(1, 0, 32'h0000_3024, 0);
    // j: {0, 0xC40, 00} = 3100.
    d_valid = 1'b1;
    jmp_op  = 3'b100;
    d_idx26 = 26'h0000C40;
    d_pc4   = 32'h0000_3010;
    step(1, 0, 32'h0000_3028, 0);
    // Branch that would be taken but d_valid is low.
    set_br(3'b001, 32'd1, 32'd1, 32'h0000_3010, 16'h0004);
    d_valid = 1'b0;
    step(1, 0, 32'h0000_3100, 0);
    // bltz taken with negative offset: 3108 - 8 = 3100.
    set_br(3'b110, 32'hFFFF_FFFF, 32'd0, 32'h0000_3108, 16'hFFFE);
    step(1, 0, 32'h0000_3104, 0);
    // blez not taken on positive rs.
    set_br(3'b100, 32'd1, 32'd0, 32'h0000_3010, 16'h0004);
    step(1, 0, 32'h0000_3100, 0);
    // jalr to top of address space, then wrap.
    d_valid = 1'b1;
    jmp_op  = 3'b111;
    rs_val  = 32'hFFFF_FFFC;
    step(1, 0, 32'h0000_3104, 0);
    step(1, 0, 32'hFFFF_FFFC, 0);
    step(1, 0, 32'h0000_0000, 0);

    // Park a branch, then assert reset mid-cycle.
    set_br(3'b010, 32'd1, 32'd2, 32'h0000_3010, 16'h0004);
    imem_req_ready = 1'b0;
    @(posedge clk);
    #1;
    clear_redirects();
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_pc", pc_f, 32'h0000_3000);
    check("async_reset_valid", {31'd0, imem_req_valid}, 32'd0);
    check("async_reset_kill", {31'd0, f_kill}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 32'h0000_3000, 0);
    step(1, 0, 32'h0000_3004, 0);
    step(1, 0, 32'h0000_3008, 0);
    imem_req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
